// File: rtl/tx_zc_pkg.sv
// Shared definitions for the Zadoff-Chu phase generator: FSM states,
// default widths and the constant relating the phase period T to Nzc.
package tx_zc_pkg;

    localparam int ZC_NZC_W_DEF = 12;
    localparam int ZC_OUT_W_DEF = 12;
    localparam int ZC_INV_W_DEF = 18;

    // The phase period is T = ZC_T_MULT * Nzc.
    localparam int ZC_T_MULT = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_RUN,
        ST_DRAIN
    } zc_state_t;

endpackage

// File: rtl/tx_zc_mod_add.sv
// Modular add (a+b mod t) or subtract (a-b mod t) for operands already in [0, t).
module tx_zc_mod_add #(
    parameter int PH_W = 17,
    parameter bit SUB  = 1'b0
) (
    input  logic [PH_W-1:0] i_a,
    input  logic [PH_W-1:0] i_b,
    input  logic [PH_W-1:0] i_t,
    output logic [PH_W-1:0] o_y
);

    logic [PH_W:0] w_sum;
    logic [PH_W:0] w_dif;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        w_sum = {1'b0, i_a} + {1'b0, i_b};
        w_dif = {1'b0, i_a} - {1'b0, i_b};
        if (SUB) begin
            o_y = w_dif[PH_W] ? PH_W'(w_dif + {1'b0, i_t}) : w_dif[PH_W-1:0];
        end else begin
            o_y = (w_sum >= {1'b0, i_t}) ? PH_W'(w_sum - {1'b0, i_t}) : w_sum[PH_W-1:0];
        end
    end

endmodule

// File: rtl/tx_zc_phase_gen.sv
// Zadoff-Chu phase sequence generator: emits the per-sample phase in turns
// using divider-free modular recurrences and a valid/ready output stream.
module tx_zc_phase_gen
    import tx_zc_pkg::*;
#(
    parameter int NZC_W  = ZC_NZC_W_DEF,
    parameter int OUT_W  = ZC_OUT_W_DEF,
    parameter int INV_W  = ZC_INV_W_DEF,
    localparam int PH_W  = NZC_W + 5
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [NZC_W-1:0] zc_N_zc,
    input  logic [NZC_W-1:0] zc_len,
    input  logic [NZC_W-1:0] zc_start_index,
    input  logic [PH_W-1:0]  zc_Q,
    input  logic [PH_W-1:0]  zc_P,
    input  logic [INV_W-1:0] zc_inv_T,
    input  logic             theta_ready,
    output logic             theta_valid,
    output logic [OUT_W-1:0] theta_data,
    output logic             theta_last,
    output logic             busy,
    output logic             cfg_err
);

    localparam int SH     = INV_W - OUT_W;
    localparam int PROD_W = PH_W + INV_W + 2;
    localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1 << (SH - 1));
    localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN  = PROD_W'(-(1 << (OUT_W - 1)));

    zc_state_t r_state;
    zc_state_t w_state_nxt;

    logic [NZC_W-1:0] r_nzc, r_len, r_sidx, r_n, r_m;
    logic [PH_W-1:0]  r_t, r_q, r_p, r_q2;
    logic [INV_W-1:0] r_inv_t;
    logic [PH_W-1:0]  r_beta, r_yita, r_d;

    logic                    r_s1_valid, r_s1_last;
    logic signed [PH_W:0]    r_s1_theta;
    logic                    r_out_valid, r_out_last, r_cfg_err;
    logic [OUT_W-1:0]        r_out_data;

    logic [PH_W-1:0]         w_t_in, w_half, w_q2, w_theta;
    logic [PH_W-1:0]         w_beta_nxt, w_yita_nxt, w_d_nxt;
    logic signed [PH_W:0]    w_theta_s;
    logic signed [PROD_W-1:0] w_prod, w_rnd, w_inv_s;
    logic [OUT_W-1:0]        w_sat;
    logic                    w_cfg_ok, w_adv, w_accept;

    assign w_t_in   = PH_W'(zc_N_zc) * PH_W'(ZC_T_MULT);
    assign w_cfg_ok = (zc_N_zc >= NZC_W'(3)) && (zc_len != '0) &&
                      (zc_start_index < zc_len) && (zc_Q < w_t_in) && (zc_P < w_t_in);
    assign w_accept = (r_state == ST_IDLE) && start && w_cfg_ok;
    // The whole pipeline advances together; a refused output freezes everything.
    assign w_adv    = !(r_out_valid && !theta_ready);
    assign w_half   = r_t >> 1;

    tx_zc_mod_add #(.PH_W(PH_W), .SUB(1'b0)) u_q2 (
        .i_a(r_q), .i_b(r_q), .i_t(r_t), .o_y(w_q2)
    );
    tx_zc_mod_add #(.PH_W(PH_W), .SUB(1'b0)) u_beta (
        .i_a(r_beta), .i_b(r_p), .i_t(r_t), .o_y(w_beta_nxt)
    );
    tx_zc_mod_add #(.PH_W(PH_W), .SUB(1'b0)) u_yita (
        .i_a(r_yita), .i_b(r_d), .i_t(r_t), .o_y(w_yita_nxt)
    );
    tx_zc_mod_add #(.PH_W(PH_W), .SUB(1'b0)) u_d (
        .i_a(r_d), .i_b(r_q2), .i_t(r_t), .o_y(w_d_nxt)
    );
    tx_zc_mod_add #(.PH_W(PH_W), .SUB(1'b1)) u_theta (
        .i_a(r_beta), .i_b(r_yita), .i_t(r_t), .o_y(w_theta)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_LATCH;
            ST_LATCH: w_state_nxt = ST_RUN;
            ST_RUN:   if (w_adv && (r_n == r_len - NZC_W'(1))) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_out_valid && r_out_last && theta_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (abort) w_state_nxt = ST_IDLE;
    end

    // Fold to [-T/2, T/2), scale to turns, round half up and saturate.
    always_comb begin
        w_theta_s = $signed({1'b0, w_theta});
        if (w_theta >= w_half) begin
            w_theta_s = $signed({1'b0, w_theta}) - $signed({1'b0, r_t});
        end
        w_inv_s = $signed(PROD_W'(r_inv_t));
        w_prod  = PROD_W'(r_s1_theta) * w_inv_s;
        w_rnd   = (w_prod + RND_HALF) >>> SH;
        if (w_rnd > SAT_MAX) begin
            w_sat = SAT_MAX[OUT_W-1:0];
        end else if (w_rnd < SAT_MIN) begin
            w_sat = SAT_MIN[OUT_W-1:0];
        end else begin
            w_sat = w_rnd[OUT_W-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_nzc <= '0; r_len <= '0; r_sidx <= '0; r_n <= '0; r_m <= '0;
            r_t <= '0; r_q <= '0; r_p <= '0; r_q2 <= '0; r_inv_t <= '0;
            r_beta <= '0; r_yita <= '0; r_d <= '0;
            r_s1_valid <= 1'b0; r_s1_last <= 1'b0; r_s1_theta <= '0;
            r_out_valid <= 1'b0; r_out_last <= 1'b0; r_out_data <= '0;
            r_cfg_err <= 1'b0;
        end else if (abort) begin
            r_s1_valid <= 1'b0; r_s1_last <= 1'b0;
            r_out_valid <= 1'b0; r_out_last <= 1'b0; r_out_data <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == ST_IDLE) && start && !w_cfg_ok;
            if (w_accept) begin
                r_nzc   <= zc_N_zc;
                r_len   <= zc_len;
                r_sidx  <= zc_start_index;
                r_t     <= w_t_in;
                r_q     <= zc_Q;
                r_p     <= zc_P;
                r_inv_t <= zc_inv_T;
            end
            if (r_state == ST_LATCH) begin
                r_q2   <= w_q2;
                r_d    <= w_q2;
                r_beta <= '0;
                r_yita <= '0;
                r_n    <= '0;
                r_m    <= '0;
            end
            if (w_adv) begin
                r_out_valid <= r_s1_valid;
                r_out_last  <= r_s1_last;
                r_out_data  <= r_s1_valid ? w_sat : '0;
                if (r_state == ST_RUN) begin
                    // Samples before the start index still advance the recurrences.
                    r_s1_valid <= (r_n >= r_sidx);
                    r_s1_last  <= (r_n == r_len - NZC_W'(1));
                    r_s1_theta <= w_theta_s;
                    r_n        <= r_n + NZC_W'(1);
                    r_beta     <= w_beta_nxt;
                    if (r_m == r_nzc - NZC_W'(1)) begin
                        r_m    <= '0;
                        r_yita <= '0;
                        r_d    <= r_q2;
                    end else begin
                        r_m    <= r_m + NZC_W'(1);
                        r_yita <= w_yita_nxt;
                        r_d    <= w_d_nxt;
                    end
                end else begin
                    r_s1_valid <= 1'b0;
                    r_s1_last  <= 1'b0;
                end
            end
        end
    end

    assign theta_valid = r_out_valid;
    assign theta_data  = r_out_data;
    assign theta_last  = r_out_last;
    assign busy        = (r_state != ST_IDLE);
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_tx_zc_phase_gen.sv
// Directed self-checking bench for tx_zc_phase_gen; expected phases come from
// a closed-form model of the Zadoff-Chu phase, independent of the recurrences.
module tb_tx_zc_phase_gen;

    localparam int NZC_W = 12;
    localparam int OUT_W = 12;
    localparam int INV_W = 18;
    localparam int PH_W  = NZC_W + 5;

    logic             sys_clk = 1'b0;
    logic             rst, start, abort, theta_ready;
    logic [NZC_W-1:0] zc_N_zc, zc_len, zc_start_index;
    logic [PH_W-1:0]  zc_Q, zc_P;
    logic [INV_W-1:0] zc_inv_T;
    logic             theta_valid, theta_last, busy, cfg_err;
    logic [OUT_W-1:0] theta_data;

    int n_assert = 0;
    int n_fail   = 0;
    int obs [0:63];
    int cur_nzc, cur_q, cur_p, cur_inv, cur_len;

    always #5 sys_clk = ~sys_clk;

    tx_zc_phase_gen dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .zc_N_zc        (zc_N_zc),
        .zc_len         (zc_len),
        .zc_start_index (zc_start_index),
        .zc_Q           (zc_Q),
        .zc_P           (zc_P),
        .zc_inv_T       (zc_inv_T),
        .theta_ready    (theta_ready),
        .theta_valid    (theta_valid),
        .theta_data     (theta_data),
        .theta_last     (theta_last),
        .busy           (busy),
        .cfg_err        (cfg_err)
    );

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Closed form: beta = n*P, yita = Q2*m*(m+1)/2 (mod T), m = n mod Nzc.
    function automatic int ref_theta(input int nzc, input int q, input int p,
                                     input int inv, input int n);
        longint t, q2, m, y, b, th, pr, r;
        t  = 24 * nzc;
        q2 = (2 * q) % t;
        m  = n % nzc;
        y  = ((m * (m + 1) / 2) * q2) % t;
        b  = (longint'(n) * p) % t;
        th = b - y;
        if (th < 0) th += t;
        if (th >= t / 2) th -= t;
        pr = th * inv;
        r  = (pr + (64'sd1 <<< (INV_W - OUT_W - 1))) >>> (INV_W - OUT_W);
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        return int'(r);
    endfunction

    task automatic record(input int n);
        check($sformatf("data[%0d]", n), $signed(theta_data),
              ref_theta(cur_nzc, cur_q, cur_p, cur_inv, n));
        check($sformatf("last[%0d]", n), theta_last, (n == cur_len - 1));
        obs[n] = $signed(theta_data);
    endtask

    // One run from a start pulse; optional stall, mid-run abort/reset (cut_kind 1/2)
    // and a start pulse with illegal config while busy (poke).
    task automatic run(input int nzc, input int q, input int p, input int inv,
                       input int len, input int sidx, input int stall_at,
                       input int cut_at, input int cut_kind, input bit poke);
        int cnt = 0;
        int first_cyc = -1;
        int stall_left = 0;
        int nexp = len - sidx;
        bit stalled = 1'b0;
        bit done = 1'b0;
        logic signed [31:0] held_data = 0;
        logic held_last = 1'b0;
        foreach (obs[i]) obs[i] = 99999;
        cur_nzc = nzc; cur_q = q; cur_p = p; cur_inv = inv; cur_len = len;
        zc_N_zc = NZC_W'(nzc); zc_Q = PH_W'(q); zc_P = PH_W'(p);
        zc_inv_T = INV_W'(inv); zc_len = NZC_W'(len); zc_start_index = NZC_W'(sidx);
        theta_ready = 1'b1;
        start = 1'b1;
        for (int j = 1; j <= 400 && !done; j++) begin
            @(negedge sys_clk);
            if (j == 1) begin
                start = 1'b0;
                check("busy_after_start", busy, 1);
                check("cfg_err_legal", cfg_err, 0);
                if (poke) begin
                    zc_N_zc = NZC_W'(2); zc_Q = PH_W'(5); zc_P = PH_W'(7); zc_len = NZC_W'(1);
                    start = 1'b1;
                end
            end else if (j == 2) begin
                start = 1'b0;
                if (poke) check("start_while_busy_no_cfg_err", cfg_err, 0);
            end
            if (theta_valid && first_cyc < 0) first_cyc = j;
            if (cut_kind != 0 && stall_left == 0 && theta_valid && cnt == cut_at) begin
                if (cut_kind == 1) abort = 1'b1; else rst = 1'b1;
                start = 1'b1;
                @(negedge sys_clk);
                abort = 1'b0; rst = 1'b0; start = 1'b0;
                check("cut_valid", theta_valid, 0);
                check("cut_data", $signed(theta_data), 0);
                check("cut_last", theta_last, 0);
                check("cut_busy", busy, 0);
                check("cut_cfg_err", cfg_err, 0);
                done = 1'b1;
            end else if (stall_left > 0) begin
                check("stall_valid", theta_valid, 1);
                check("stall_data", $signed(theta_data), held_data);
                check("stall_last", theta_last, held_last);
                stall_left--;
                if (stall_left == 0) begin
                    theta_ready = 1'b1;
                    record(sidx + cnt);
                    cnt++;
                end
            end else if (theta_valid && theta_ready) begin
                if (cnt == stall_at && !stalled) begin
                    stalled = 1'b1;
                    theta_ready = 1'b0;
                    held_data = $signed(theta_data);
                    held_last = theta_last;
                    stall_left = 5;
                end else begin
                    record(sidx + cnt);
                    cnt++;
                end
            end
            if (cnt == nexp) done = 1'b1;
        end
        if (cut_kind != 0) begin
            check("cut_reached", cnt, cut_at);
        end else begin
            check("sample_count", cnt, nexp);
            check("first_valid_latency", first_cyc, 4 + sidx);
            @(negedge sys_clk);
            check("busy_after_last", busy, 0);
            check("valid_after_last", theta_valid, 0);
        end
    endtask

    task automatic cfg_bad(input string tag, input int nzc, input int len,
                           input int sidx, input int q, input int p);
        zc_N_zc = NZC_W'(nzc); zc_len = NZC_W'(len); zc_start_index = NZC_W'(sidx);
        zc_Q = PH_W'(q); zc_P = PH_W'(p); zc_inv_T = INV_W'(352);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        check({tag, "_cfg_err_pulse"}, cfg_err, 1);
        check({tag, "_busy_low"}, busy, 0);
        @(negedge sys_clk);
        check({tag, "_cfg_err_one_cycle"}, cfg_err, 0);
        check({tag, "_busy_stays_low"}, busy, 0);
        check({tag, "_no_valid"}, theta_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; theta_ready = 1'b1;
        zc_N_zc = '0; zc_len = '0; zc_start_index = '0;
        zc_Q = '0; zc_P = '0; zc_inv_T = '0;
        repeat (3) @(negedge sys_clk);
        check("reset_valid", theta_valid, 0);
        check("reset_data", $signed(theta_data), 0);
        check("reset_last", theta_last, 0);
        check("reset_busy", busy, 0);
        check("reset_cfg_err", cfg_err, 0);
        rst = 1'b0;
        @(negedge sys_clk);

        // Nzc=31, Q=12, P=0, 36 samples: m wraps at n=31.
        run(31, 12, 0, 352, 36, 0, -1, -1, 0, 1'b0);
        check("A_n0", obs[0], 0);
        check("A_n1", obs[1], -132);
        check("A_n31", obs[31], 0);

        // Pure cyclic shift: beta alternates 0, T/2.
        run(31, 0, 372, 352, 8, 0, -1, -1, 0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            check($sformatf("B_alt[%0d]", n), obs[n], (n % 2 == 1) ? -2046 : 0);
        end

        // Five-cycle stall at n=10 plus an ignored start with illegal inputs.
        run(31, 12, 0, 352, 36, 0, 10, -1, 0, 1'b1);
        check("C_n1", obs[1], -132);

        // Samples before start index are dropped.
        run(31, 12, 0, 352, 12, 5, -1, -1, 0, 1'b0);
        check("D_first_n5", obs[5], -1980);

        cfg_bad("nzc2", 2, 8, 0, 0, 0);
        cfg_bad("len0", 31, 0, 0, 0, 0);
        cfg_bad("sidx_ge_len", 31, 8, 8, 0, 0);
        cfg_bad("q_ge_t", 31, 8, 0, 744, 0);
        cfg_bad("p_ge_t", 31, 8, 0, 0, 744);

        // Abort, then reset, at n=20; each followed by a fresh full run.
        run(31, 12, 0, 352, 36, 0, -1, 20, 1, 1'b0);
        run(31, 12, 0, 352, 36, 0, -1, -1, 0, 1'b0);
        check("after_abort_n1", obs[1], -132);
        run(31, 12, 0, 352, 36, 0, -1, 20, 2, 1'b0);
        run(31, 12, 0, 352, 36, 0, -1, -1, 0, 1'b0);
        check("after_rst_n31", obs[31], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
